// File: rtl/alu_share_arbiter_if.sv
// Requester-side handshake bundle for alu_share_arbiter: two request ports,
// two response handshakes and the shared registered result.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  req0_valid;
  logic                  req0_ready;
  logic [15:0]           req0_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [15:0]           req1_op;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_out;
  logic                  rsp_branch;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_out, rsp_branch,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_out, rsp_branch,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one external combinational ALU between two
// requesters: accept -> execute -> respond, with per-requester grant counters.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_arbiter_if.slave    bus,
  output logic                  alu_E,
  output logic [15:0]           alu_op,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_branch,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  alu_e_q, alu_e_d;
  logic [15:0]           alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [DATA_WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic                  rsp_branch_q, rsp_branch_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  logic grant_sel;
  logic accept;
  logic owner_ready;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    grant_sel      = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    bus.req0_ready = rst_n && (state_q == S_IDLE) && bus.req0_valid && !grant_sel;
    bus.req1_ready = rst_n && (state_q == S_IDLE) && bus.req1_valid &&  grant_sel;
    accept         = bus.req0_ready || bus.req1_ready;
    owner_ready    = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_e_d      = alu_e_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_out_d    = rsp_out_q;
    rsp_branch_d = rsp_branch_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_e_d      = 1'b1;
          alu_op_d     = grant_sel ? bus.req1_op : bus.req0_op;
          alu_a_d      = grant_sel ? bus.req1_a  : bus.req0_a;
          alu_b_d      = grant_sel ? bus.req1_b  : bus.req0_b;
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          if (grant_sel) cnt1_d = cnt1_q + CNT_WIDTH'(1);
          else           cnt0_d = cnt0_q + CNT_WIDTH'(1);
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU inputs drop back to idle as soon as the result is captured.
        rsp_out_d    = alu_out;
        rsp_branch_d = alu_branch;
        alu_e_d      = 1'b0;
        alu_op_d     = '0;
        alu_a_d      = '0;
        alu_b_d      = '0;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d = owner_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (owner_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          alu_e_d      = 1'b0;
          alu_op_d     = '0;
          alu_a_d      = '0;
          alu_b_d      = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_e_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_out_q    <= '0;
      rsp_branch_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_e_q      <= alu_e_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_out_q    <= rsp_out_d;
      rsp_branch_q <= rsp_branch_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign alu_E          = alu_e_q;
  assign alu_op         = alu_op_q;
  assign alu_A          = alu_a_q;
  assign alu_B          = alu_b_q;
  assign bus.rsp_out    = rsp_out_q;
  assign bus.rsp_branch = rsp_branch_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign grant_cnt0     = cnt0_q;
  assign grant_cnt1     = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a small external ALU model.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  logic          alu_E;
  logic [15:0]   alu_op;
  logic [DW-1:0] alu_A, alu_B, alu_out;
  logic          alu_branch;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  alu_share_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_E      (alu_E),
    .alu_op     (alu_op),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_out    (alu_out),
    .alu_branch (alu_branch),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  function automatic logic [DW-1:0] ref_out(input logic [15:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      16'h0033: return a + b;
      16'h4033: return a - b;
      16'h0433: return a ^ b;
      16'h0063: return a + b;
      default:  return '0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [15:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (op == 16'h0063) && (a == b);
  endfunction

  always_comb begin
    alu_out    = alu_E ? ref_out(alu_op, alu_A, alu_B) : '0;
    alu_branch = alu_E ? ref_br(alu_op, alu_A, alu_B) : 1'b0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] out;
    logic          br;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];

  task automatic pop_cmp(input logic k);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("rsp_unexpected", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_eq("rsp_owner", 32'(k), 32'(e.owner));
      check_eq("rsp_out", bus.rsp_out, e.out);
      check_eq("rsp_branch", 32'(bus.rsp_branch), 32'(e.br));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.req0_valid && bus.req1_valid)
        check_eq("one_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
      if (bus.rsp0_valid || bus.rsp1_valid)
        check_eq("rsp_excl", 32'(bus.rsp0_valid & bus.rsp1_valid), 0);
      if (bus.req0_ready) begin
        sb.push_back(exp_t'{1'b0, ref_out(bus.req0_op, bus.req0_a, bus.req0_b),
                            ref_br(bus.req0_op, bus.req0_a, bus.req0_b)});
        grant_log.push_back(1'b0);
      end
      if (bus.req1_ready) begin
        sb.push_back(exp_t'{1'b1, ref_out(bus.req1_op, bus.req1_a, bus.req1_b),
                            ref_br(bus.req1_op, bus.req1_a, bus.req1_b)});
        grant_log.push_back(1'b1);
      end
      if (bus.rsp0_valid && bus.rsp0_ready) pop_cmp(1'b0);
      if (bus.rsp1_valid && bus.rsp1_ready) pop_cmp(1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [15:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
  endtask

  task automatic set_req1(input logic [15:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
  endtask

  // Drops each valid after its accept and waits until every response is taken.
  task automatic drain(input int budget);
    int   cyc;
    logic a0, a1, done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      a0 = bus.req0_ready;
      a1 = bus.req1_ready;
      step();
      cyc++;
      if (a0) bus.req0_valid = 1'b0;
      if (a1) bus.req1_valid = 1'b0;
      done = !bus.req0_valid && !bus.req1_valid && (sb.size() == 0) &&
             !bus.rsp0_valid && !bus.rsp1_valid;
    end
    if (!done) check_eq("drain_timeout", 32'(done), 1);
  endtask

  task automatic run_fair(input int target);
    int cyc;
    cyc = 0;
    grant_log.delete();
    set_req0(16'h0033, 1, 2);
    set_req1(16'h4033, 9, 4);
    while (grant_log.size() < target && cyc < 400) begin
      step();
      cyc++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check_eq("fair_grants", 32'(grant_log.size()), 32'(target));
    drain(20);
    for (int i = 0; i < grant_log.size(); i++)
      check_eq("fair_alternate", 32'(grant_log[i]), 32'(i % 2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_req0_ready", 32'(bus.req0_ready), 0);
    check_eq("rst_alu_E", 32'(alu_E), 0);
    check_eq("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
    check_eq("rst_rsp_out", bus.rsp_out, 0);
    check_eq("rst_cnt0", 32'(grant_cnt0), 0);
    step();
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single ADD with cycle-level timing.
    set_req0(16'h0033, 5, 7);
    @(negedge clk);
    check_eq("add_req0_ready", 32'(bus.req0_ready), 1);
    check_eq("add_req1_ready", 32'(bus.req1_ready), 0);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_eq("add_exec_alu_E", 32'(alu_E), 1);
    check_eq("add_exec_alu_op", 32'(alu_op), 32'h0033);
    check_eq("add_exec_alu_A", alu_A, 5);
    check_eq("add_exec_alu_B", alu_B, 7);
    check_eq("add_exec_rsp0_valid", 32'(bus.rsp0_valid), 0);
    @(negedge clk);
    check_eq("add_resp_rsp0_valid", 32'(bus.rsp0_valid), 1);
    check_eq("add_resp_rsp1_valid", 32'(bus.rsp1_valid), 0);
    check_eq("add_resp_out", bus.rsp_out, 32'hC);
    check_eq("add_resp_alu_E", 32'(alu_E), 0);
    @(negedge clk);
    check_eq("add_done_rsp0_valid", 32'(bus.rsp0_valid), 0);
    check_eq("add_cnt0", 32'(grant_cnt0), 1);
    check_eq("add_cnt1", 32'(grant_cnt1), 0);

    // Contention straight after reset: requester 0 first.
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    set_req0(16'h4033, 10, 3);
    set_req1(16'h0433, 32'hF0, 32'hFF);
    @(negedge clk);
    check_eq("cont_req0_ready", 32'(bus.req0_ready), 1);
    check_eq("cont_req1_ready", 32'(bus.req1_ready), 0);
    step();
    bus.req0_valid = 1'b0;
    drain(20);
    check_eq("cont_cnt0", 32'(grant_cnt0), 1);
    check_eq("cont_cnt1", 32'(grant_cnt1), 1);

    // Branch flag set/clear, then an undecoded opcode.
    set_req1(16'h0063, 3, 3);
    drain(20);
    set_req1(16'h0063, 3, 4);
    drain(20);
    set_req1(16'h7FFF, 9, 9);
    drain(20);

    // Backpressure on rsp0 while req1 waits.
    bus.rsp0_ready = 1'b0;
    set_req0(16'h0033, 100, 23);
    set_req1(16'h0433, 32'hAA, 32'h55);
    @(negedge clk);
    check_eq("bp_req0_ready", 32'(bus.req0_ready), 1);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_exec_req1_ready", 32'(bus.req1_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_rsp0_valid", 32'(bus.rsp0_valid), 1);
      check_eq("bp_rsp_out", bus.rsp_out, 123);
      check_eq("bp_req1_ready", 32'(bus.req1_ready), 0);
    end
    step();
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_hs_rsp0_valid", 32'(bus.rsp0_valid), 1);
    check_eq("bp_hs_req1_ready", 32'(bus.req1_ready), 0);
    step();
    @(negedge clk);
    check_eq("bp_after_req1_ready", 32'(bus.req1_ready), 1);
    drain(20);

    // Reset during EXEC drops the request.
    set_req0(16'h0033, 1, 1);
    @(negedge clk);
    check_eq("rx_req0_ready", 32'(bus.req0_ready), 1);
    step();
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rx_exec_alu_E", 32'(alu_E), 1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rx_alu_E", 32'(alu_E), 0);
    check_eq("rx_alu_op", 32'(alu_op), 0);
    check_eq("rx_alu_A", alu_A, 0);
    check_eq("rx_rsp_out", bus.rsp_out, 0);
    check_eq("rx_rsp_branch", 32'(bus.rsp_branch), 0);
    check_eq("rx_cnt0", 32'(grant_cnt0), 0);
    check_eq("rx_cnt1", 32'(grant_cnt1), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rx_rsp0_valid", 32'(bus.rsp0_valid), 0);
    end
    step();

    // Continuous contention: 20 grants, then 20 more to wrap 4-bit counters.
    run_fair(20);
    check_eq("fair_cnt0", 32'(grant_cnt0), 10);
    check_eq("fair_cnt1", 32'(grant_cnt1), 10);
    run_fair(20);
    check_eq("wrap_cnt0", 32'(grant_cnt0), 4);
    check_eq("wrap_cnt1", 32'(grant_cnt1), 4);
    check_eq("sb_empty_end", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
